fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the byte-addressed, big-endian instruction memory.
- Holds the program counter and drives the memory address.
- Takes back the combinationally read 32-bit instruction and registers it, with its PC+4, into the IF/ID pipeline register for decode.
- Handles load-use stalls, taken-branch and jump redirects (no delay slot), and out-of-range fetch detection.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_BYTES, 256, instruction memory size in bytes. Legal fetch requires pc <= IMEM_BYTES-4.
- NOP_INSTR, 32'h0000_0000, bubble instruction (sll $0,$0,0).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hazard unit: hold PC and IF/ID.
- branch_taken  in  1  EX-stage branch resolved taken.
- branch_target  in  32  branch destination byte address.
- jump  in  1  ID-stage j/jal/jr.
- jump_target  in  32  jump destination byte address.
- imem_addr  out  32  byte address to instruction memory (= pc).
- imem_instr  in  32  instruction word returned combinationally, same cycle.
- ifid_instr  out  32  registered instruction to decode.
- ifid_pc4  out  32  registered PC+4 of that instruction.
- ifid_valid  out  1  IF/ID holds a real instruction (0 = bubble).
- fetch_fault  out  1  sticky: attempted fetch outside memory.
- fetch_count  out  32  count of valid instructions delivered into IF/ID.

Behaviour:
- One clock, clk. Reset is synchronous and active-high (rst sampled on the rising edge of clk only).
- On reset:
  - pc = RESET_PC.
  - ifid_instr = NOP_INSTR, ifid_pc4 = 0, ifid_valid = 0.
  - fetch_fault = 0, fetch_count = 0.
- Reset overrides every other input. Reset mid-stall or mid-redirect discards all state.
- imem_addr = pc, combinational from the PC register. Memory read is combinational, so imem_instr is consumed in the same cycle. Fetch latency: 1 cycle from PC to IF/ID.
- in_range = (pc <= IMEM_BYTES-4). Compare in 32-bit unsigned.
- Per-edge priority, highest first:
  1. rst: reset values above.
  2. branch_taken: pc <= {branch_target[31:2],2'b00}. IF/ID <= bubble (NOP_INSTR, valid 0, pc4 0). Overrides jump and stall; the branch is the older instruction.
  3. jump: pc <= {jump_target[31:2],2'b00}. IF/ID <= bubble. Overrides stall.
  4. stall: pc, IF/ID, and fetch_count hold.
  5. Normal:
     - in_range: pc <= pc+4 (32-bit wrap); ifid_instr <= imem_instr; ifid_pc4 <= pc+4; ifid_valid <= 1; fetch_count <= fetch_count+1 (wraps at 2^32).
     - !in_range: pc holds; IF/ID <= bubble; fetch_fault <= 1.
- Redirect targets always have bits [1:0] forced to 00; misaligned low bits are silently dropped.
- fetch_fault is sticky until rst. Once set, a later redirect into range resumes normal fetch but does not clear the flag.
- fetch_count increments only on edges that load a valid instruction. Bubbles, stalls, and redirects do not increment it.
- All outputs except imem_addr are registered.

Decomposition:
- Shared package mips_pkg:
  - constants RESET_PC_DEFAULT, NOP_INSTR, WORD_BYTES=4.
  - typedef ifid_t {instr[31:0], pc4[31:0], valid}, reused by decode.
- One natural sub-module: pc_reg. It holds the PC, performs priority next-PC select and alignment, and computes in_range. fetch_stage wraps it with the IF/ID register, fault flag, and counter.

Test Plan:
- Reset then 4 free-running cycles with memory words W0..W3 at 0,4,8,12:
  - imem_addr sequences 0,4,8,12,16.
  - ifid_instr = W0..W3 one cycle later; ifid_pc4 = 4,8,12,16; fetch_count = 4.
- Stall high for 2 cycles while pc=8:
  - imem_addr stays 8; IF/ID holds W1/pc4=8; fetch_count unchanged.
  - After release, W2 is delivered.
- branch_taken=1, branch_target=32'h0000_0042, together with jump=1 and stall=1:
  - next pc=32'h40; ifid_valid=0, ifid_instr=NOP.
  - Next cycle ifid_instr = word at 0x40.
- Jump only, jump_target=32'h20:
  - next pc=32'h20, one bubble, then the word at 0x20 with ifid_pc4=32'h24.
- Sequential fetch reaching pc=252 (IMEM_BYTES=256):
  - word at 252 delivered valid; pc becomes 256.
  - Bubbles follow; fetch_fault=1 and pc holds at 256.
  - A branch to 0 then resumes fetch, with fetch_fault still 1.
- rst asserted for 1 cycle during an active stall, with fetch_fault=1 and fetch_count=7:
  - all outputs return to reset values on that edge.
  - Fetch restarts at RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: reset/bubble constants and the IF/ID
// register layout that decode also consumes.
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;  // sll $0,$0,0
    localparam int unsigned WORD_BYTES       = 4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } ifid_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect controls in, instruction memory port,
// and the IF/ID outputs toward decode.
interface fetch_stage_if;

    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic        fetch_fault;
    logic [31:0] fetch_count;

    modport master (
        input  stall, branch_taken, branch_target, jump, jump_target, imem_instr,
        output imem_addr, ifid_instr, ifid_pc4, ifid_valid, fetch_fault, fetch_count
    );

    modport slave (
        output stall, branch_taken, branch_target, jump, jump_target, imem_instr,
        input  imem_addr, ifid_instr, ifid_pc4, ifid_valid, fetch_fault, fetch_count
    );

endinterface

// File: rtl/pc_reg.sv
// Program counter with prioritised next-PC selection (branch > jump > stall
// > sequential), word alignment of redirect targets, and range detection.
module pc_reg
    import mips_pkg::WORD_BYTES;
#(
    parameter logic [31:0] RESET_PC   = mips_pkg::RESET_PC_DEFAULT,
    parameter int unsigned IMEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        in_range
);

    localparam logic [31:0] ALIGN_MASK = ~32'(WORD_BYTES - 1);
    localparam logic [31:0] LAST_PC    = 32'(IMEM_BYTES - WORD_BYTES);

    always_comb begin
        pc_plus4 = pc + 32'(WORD_BYTES);
        in_range = (pc <= LAST_PC);
    end

    // An out-of-range PC parks in place until a redirect moves it.
    always_ff @(posedge clk) begin
        if (rst)
            pc <= RESET_PC;
        else if (branch_taken)
            pc <= branch_target & ALIGN_MASK;
        else if (jump)
            pc <= jump_target & ALIGN_MASK;
        else if (!stall && in_range)
            pc <= pc_plus4;
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: drives the PC to instruction memory and registers the
// returned word with its PC+4 into IF/ID; tracks fetch faults and count.
module fetch_stage
    import mips_pkg::ifid_t;
#(
    parameter logic [31:0] RESET_PC   = mips_pkg::RESET_PC_DEFAULT,
    parameter int unsigned IMEM_BYTES = 256,
    parameter logic [31:0] NOP_INSTR  = mips_pkg::NOP_INSTR
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);

    localparam ifid_t BUBBLE = '{instr: NOP_INSTR, pc4: 32'h0, valid: 1'b0};

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        in_range;
    ifid_t       ifid_p1;
    logic        fetch_fault_p1;
    logic [31:0] fetch_count_p1;

    pc_reg #(
        .RESET_PC   (RESET_PC),
        .IMEM_BYTES (IMEM_BYTES)
    ) u_pc_reg (
        .clk           (clk),
        .rst           (rst),
        .stall         (bus.stall),
        .branch_taken  (bus.branch_taken),
        .branch_target (bus.branch_target),
        .jump          (bus.jump),
        .jump_target   (bus.jump_target),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .in_range      (in_range)
    );

    // IF -> IF/ID boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_p1        <= BUBBLE;
            fetch_fault_p1 <= 1'b0;
            fetch_count_p1 <= 32'h0;
        end else if (bus.branch_taken || bus.jump) begin
            ifid_p1 <= BUBBLE;
        end else if (!bus.stall) begin
            if (in_range) begin
                ifid_p1        <= '{instr: bus.imem_instr, pc4: pc_plus4, valid: 1'b1};
                fetch_count_p1 <= fetch_count_p1 + 32'd1;
            end else begin
                ifid_p1        <= BUBBLE;
                fetch_fault_p1 <= 1'b1;
            end
        end
    end

    assign bus.imem_addr   = pc;
    assign bus.ifid_instr  = ifid_p1.instr;
    assign bus.ifid_pc4    = ifid_p1.pc4;
    assign bus.ifid_valid  = ifid_p1.valid;
    assign bus.fetch_fault = fetch_fault_p1;
    assign bus.fetch_count = fetch_count_p1;

endmodule
